// File: rtl/acc_requant.sv
// Requantizer: adds a per-channel bias to a 32-bit MAC accumulator, then applies a round-half-up right shift and saturates to OUT_W bits.
// Latency: 2 cycles from input transfer to out_valid, with a throughput of 1 word/cycle.
// Backpressure: valid/ready on both sides. Outputs hold while stalled. Optional ReLU clamp is enabled by defining ACC_REQUANT_RELU_EN.
module acc_requant #(
  parameter  int NCH   = 16,
  parameter  int OUT_W = 17,
  localparam int CW    = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    sclr_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_acc,
  input  logic                    in_last,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_bias_we,
  input  logic [CW-1:0]           cfg_bias_addr,
  input  logic signed [31:0]      cfg_bias_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic [CW-1:0]           out_chan
);

  localparam logic signed [33:0] SAT_MAX = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
  localparam logic signed [33:0] SAT_MIN = -(34'sd1 <<< (OUT_W - 1));

  // Bias table and channel counter
  logic signed [31:0] bias_q [NCH];
  logic signed [31:0] bias_d [NCH];
  logic [CW-1:0]      chan_q, chan_d;

  // Stage 1: biased sum plus the side-band fields sampled at acceptance
  logic               s1_vld_q, s1_vld_d;
  logic signed [32:0] s1_sum_q, s1_sum_d;
  logic [CW-1:0]      s1_chan_q, s1_chan_d;
  logic               s1_last_q, s1_last_d;
  logic [4:0]         s1_shift_q, s1_shift_d;

  // Stage 2: output register
  logic                    out_vld_q, out_vld_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [CW-1:0]           out_chan_q, out_chan_d;

  logic               s2_load;
  logic               in_xfer;
  logic signed [31:0] bias_rd;
  logic signed [33:0] sum_ext;
  logic signed [33:0] rnd_add;
  logic signed [33:0] shifted;
  logic signed [33:0] sat_val;

  // Handshake: stage 2 loads when it is empty or its word leaves this edge.
  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    s2_load  = s1_vld_q && (!out_vld_q || out_ready);
    in_ready = sclr_n && (!s1_vld_q || s2_load);
    in_xfer  = in_valid && in_ready;
  end

  // Stage-1 capture. The bias is read before this edge's table write, so a
  // same-edge write to this channel is seen only by later words.
  always_comb begin
    bias_rd    = bias_q[chan_q];
    s1_vld_d   = s1_vld_q;
    s1_sum_d   = s1_sum_q;
    s1_chan_d  = s1_chan_q;
    s1_last_d  = s1_last_q;
    s1_shift_d = s1_shift_q;
    if (in_xfer) begin
      s1_vld_d   = 1'b1;
      s1_sum_d   = {in_acc[31], in_acc} + {bias_rd[31], bias_rd};
      s1_chan_d  = chan_q;
      s1_last_d  = in_last;
      s1_shift_d = cfg_shift;
    end else if (s2_load) begin
      s1_vld_d   = 1'b0;
    end
  end

  // Channel counter: advances per accepted word, restarts after a frame end
  always_comb begin
    chan_d = chan_q;
    if (in_xfer) begin
      if (in_last || chan_q == CW'(NCH - 1)) begin
        chan_d = '0;
      end else begin
        chan_d = chan_q + CW'(1);
      end
    end
  end

  // Bias table write port, independent of the datapath state
  always_comb begin
    bias_d = bias_q;
    if (cfg_bias_we) begin
      bias_d[cfg_bias_addr] = cfg_bias_data;
    end
  end

  // Round half up, apply the optional ReLU, then saturate to the output range
  always_comb begin
    sum_ext = {s1_sum_q[32], s1_sum_q};
    rnd_add = '0;
    if (s1_shift_q == 5'd0) begin
      shifted = sum_ext;
    end else begin
      rnd_add = 34'sd1 <<< (s1_shift_q - 5'd1);
      shifted = (sum_ext + rnd_add) >>> s1_shift_q;
    end
`ifdef ACC_REQUANT_RELU_EN
    if (shifted < 34'sd0) begin
      shifted = '0;
    end
`endif
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN;
    end else begin
      sat_val = shifted;
    end
  end

  // Stage-2 output register: it reloads on s2_load and otherwise holds its value while stalled
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_chan_d = out_chan_q;
    if (s2_load) begin
      out_vld_d  = 1'b1;
      out_data_d = OUT_W'(sat_val);
      out_last_d = s1_last_q;
      out_chan_d = s1_chan_q;
    end else if (out_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  // All state registers. Reset clears the pipeline, the counter and the bias table.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      for (int i = 0; i < NCH; i++) begin
        bias_q[i] <= '0;
      end
      chan_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_chan_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_shift_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_chan_q <= '0;
    end else begin
      bias_q     <= bias_d;
      chan_q     <= chan_d;
      s1_vld_q   <= s1_vld_d;
      s1_sum_q   <= s1_sum_d;
      s1_chan_q  <= s1_chan_d;
      s1_last_q  <= s1_last_d;
      s1_shift_q <= s1_shift_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_chan_q <= out_chan_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_acc_requant.sv
// Testbench for acc_requant: directed corner cases plus a randomized stream checked against a behavioural model.
// The model computes each expected output arithmetically at input acceptance and queues it in order.
// A single monitor process compares every valid output against that queue and also checks stall stability.
module tb_acc_requant;

  localparam int NCH   = 16;
  localparam int OUT_W = 17;
  localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OUT_W - 1));

  logic                    clk = 1'b0;
  logic                    sclr_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [31:0]      in_acc;
  logic                    in_last;
  logic [4:0]              cfg_shift;
  logic                    cfg_bias_we;
  logic [3:0]              cfg_bias_addr;
  logic signed [31:0]      cfg_bias_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;
  logic [3:0]              out_chan;

  acc_requant #(.NCH(NCH), .OUT_W(OUT_W)) dut (
    .clk(clk), .sclr_n(sclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
    .cfg_shift(cfg_shift), .cfg_bias_we(cfg_bias_we), .cfg_bias_addr(cfg_bias_addr),
    .cfg_bias_data(cfg_bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint data;
    int     chan;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   obs_q[$];
  longint m_bias [NCH];
  int     m_chan = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference requantizer: biased sum, round half up, optional ReLU, clamp
  function automatic longint model(input longint acc, input longint b, input int s);
    longint sum;
    longint r;
    sum = acc + b;
    if (s == 0) r = sum;
    else        r = (sum + (longint'(1) << (s - 1))) >>> s;
`ifdef ACC_REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
    return r;
  endfunction

  // Monitor: samples on the falling edge, between active edges
  bit                      stalled = 0;
  logic signed [OUT_W-1:0] prev_data;
  logic                    prev_last;
  logic [3:0]              prev_chan;

  always @(negedge clk) begin
    if (!sclr_n) begin
      exp_q.delete();
      m_chan  = 0;
      stalled = 0;
      for (int i = 0; i < NCH; i++) m_bias[i] = 0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", longint'(out_data), longint'(prev_data));
        check("stall_chan_held", out_chan, prev_chan);
        check("stall_last_held", out_last, prev_last);
      end
      if (out_valid) begin
        exp_t o;
        o.data = longint'(out_data);
        o.chan = int'(out_chan);
        o.last = out_last;
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", longint'(out_data), exp_q[0].data);
          check("out_chan", out_chan, exp_q[0].chan);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_chan = out_chan;
      prev_last = out_last;
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = model(longint'(in_acc), m_bias[m_chan], int'(cfg_shift));
        e.chan = m_chan;
        e.last = in_last;
        exp_q.push_back(e);
        m_chan = in_last ? 0 : (m_chan + 1) % NCH;
      end
      if (cfg_bias_we) m_bias[cfg_bias_addr] = longint'(cfg_bias_data);
    end
  end

  task automatic wr_bias(input int addr, input longint data);
    cfg_bias_we   = 1'b1;
    cfg_bias_addr = addr[3:0];
    cfg_bias_data = data[31:0];
    @(posedge clk); #1;
    cfg_bias_we   = 1'b0;
  endtask

  // Send one word into an empty pipe with out_ready high. An optional bias
  // write can be issued on the same edge. Returns the result and its latency.
  task automatic send_word(input logic [31:0] acc, input bit last, input bit we,
                           input int waddr, input longint wdata,
                           output longint got, output int gchan, output int lat);
    bit ok = 0;
    got = 0; gchan = -1; lat = -1;
    in_valid = 1'b1; in_acc = acc; in_last = last;
    cfg_bias_we = we; cfg_bias_addr = waddr[3:0]; cfg_bias_data = wdata[31:0];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_bias_we = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = longint'(out_data); gchan = int'(out_chan); lat = n;
        break;
      end
    end
    if (lat < 0) check("send_output_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    longint got;
    int     gch;
    int     lat;
    int     k;
    bit     xfer;

    sclr_n = 1'b0; in_valid = 1'b0; in_acc = '0; in_last = 1'b0; cfg_shift = '0;
    cfg_bias_we = 1'b0; cfg_bias_addr = '0; cfg_bias_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    sclr_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Bias 100, shift 2, acc 1000: (1100 + 2) >> 2 = 275 on channel 0
    wr_bias(0, 100);
    cfg_shift = 5'd2;
    send_word(32'd1000, 1'b1, 1'b0, 0, 0, got, gch, lat);
    check("basic_data", got, 275);
    check("basic_chan", gch, 0);
    check("basic_latency", lat, 2);

    // Saturation at both ends with shift 0
    wr_bias(0, 'h100);
    cfg_shift = 5'd0;
    send_word(32'h7FFFFFF0, 1'b1, 1'b0, 0, 0, got, gch, lat);
    check("sat_pos", got, 65535);
    send_word(32'h80000000, 1'b1, 1'b0, 0, 0, got, gch, lat);
`ifdef ACC_REQUANT_RELU_EN
    check("sat_neg_relu", got, 0);
`else
    check("sat_neg", got, -65536);
`endif

    // Reset with two words in flight while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_acc = 32'd5; in_last = 1'b0;
    @(posedge clk); #1;
    in_acc = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    sclr_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk); #1;
    sclr_n = 1'b1; out_ready = 1'b1;
    send_word(32'd50, 1'b1, 1'b0, 0, 0, got, gch, lat);
    check("after_rst_data", got, 50);
    check("after_rst_chan", gch, 0);

    // 18-word frame stream with in_last on the 5th word
    obs_q.delete();
    k = 0;
    in_valid = 1'b1;
    while (k < 18) begin
      in_acc  = $urandom;
      in_last = (k == 4);
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) k++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("frame_count", obs_q.size(), 18);
    for (int i = 0; i < 18 && i < obs_q.size(); i++) begin
      check("frame_chan", obs_q[i].chan, (i < 5) ? i : i - 5);
      check("frame_last", obs_q[i].last, (i == 4));
    end

    // Same-edge bias write: the channel-3 word sees the old bias and the next sees 7
    send_word(32'd1, 1'b1, 1'b0, 0, 0, got, gch, lat);
    for (int i = 0; i < 3; i++) send_word(32'd0, 1'b0, 1'b0, 0, 0, got, gch, lat);
    send_word(32'd10, 1'b1, 1'b1, 3, 7, got, gch, lat);
    check("same_edge_chan", gch, 3);
    check("same_edge_old_bias", got, 10);
    for (int i = 0; i < 3; i++) send_word(32'd0, 1'b0, 1'b0, 0, 0, got, gch, lat);
    send_word(32'd10, 1'b1, 1'b0, 0, 0, got, gch, lat);
    check("next_word_new_bias", got, 17);

    // Randomized stream with random backpressure, shift changes and bias writes
    xfer = 1;
    for (int c = 0; c < 800; c++) begin
      if (!in_valid || xfer) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       in_acc = 32'h7FFFFFFF;
          1:       in_acc = 32'h80000000;
          default: in_acc = $urandom;
        endcase
        in_last = ($urandom_range(0, 7) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) cfg_shift = 5'($urandom_range(0, 31));
      cfg_bias_we   = ($urandom_range(0, 5) == 0);
      cfg_bias_addr = 4'($urandom_range(0, NCH - 1));
      cfg_bias_data = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($signed(16'($urandom)));
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_bias_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
